// File: rtl/player_collision_sequencer_if.sv
// player_collision_sequencer_if: tick/restart, playfield read port and status bundle for the player-1 collision sequencer.
interface player_collision_sequencer_if #(
    parameter int DATAWIDTH = 8,
    parameter int ROWADDR_W = 3,
    parameter int LIVES_W   = 2
);
    logic                 PCS_frame_tick;
    logic                 PCS_restart;
    logic [DATAWIDTH-1:0] PCS_pos_jug1;
    logic [DATAWIDTH-1:0] PCS_row_data;
    logic                 PCS_row_rd_en;
    logic [ROWADDR_W-1:0] PCS_row_addr;
    logic                 PCS_busy;
    logic                 PCS_done;
    logic                 PCS_hit;
    logic [LIVES_W-1:0]   PCS_lives;
    logic                 PCS_game_over;
    logic                 PCS_overrun;

    modport master (
        output PCS_frame_tick, PCS_restart, PCS_pos_jug1, PCS_row_data,
        input  PCS_row_rd_en, PCS_row_addr, PCS_busy, PCS_done, PCS_hit,
               PCS_lives, PCS_game_over, PCS_overrun
    );

    modport slave (
        input  PCS_frame_tick, PCS_restart, PCS_pos_jug1, PCS_row_data,
        output PCS_row_rd_en, PCS_row_addr, PCS_busy, PCS_done, PCS_hit,
               PCS_lives, PCS_game_over, PCS_overrun
    );
endinterface

// File: rtl/player_collision_sequencer.sv
// player_collision_sequencer: per-frame player-1 collision check, lives and game-over tracking.
// Optional post-hit invulnerability window enabled by defining PCS_GRACE_EN.
module player_collision_sequencer #(
    parameter int DATAWIDTH  = 8,
    parameter int ROWADDR_W  = 3,
    parameter int PLAYER_ROW = 0,
    parameter int LIVES_INIT = 3,
    parameter int LIVES_W    = 2
`ifdef PCS_GRACE_EN
    , parameter int GRACE_FRAMES = 4
`endif
) (
    input logic PCS_CLOCK_50,
    input logic PCS_RESET_InHigh,
    player_collision_sequencer_if.slave pcs
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, CMP, OVER} stateType;

    stateType             state, stateNext;
    logic [DATAWIDTH-1:0] rowLatch;
    logic [LIVES_W-1:0]   lives;
    logic                 overrun, busy, collision, loseLife;
`ifdef PCS_GRACE_EN
    localparam int GRACE_W = $clog2(GRACE_FRAMES + 1);
    logic [GRACE_W-1:0] graceCnt;
`endif

    assign busy      = state inside {READ, WAIT, CMP};
    assign collision = |(rowLatch & pcs.PCS_pos_jug1);

    always_comb begin
`ifdef PCS_GRACE_EN
        loseLife = collision && graceCnt == '0 && lives != '0;
`else
        loseLife = collision && lives != '0;
`endif
        stateNext = state;
        case (state)
            IDLE:    stateNext = pcs.PCS_frame_tick ? READ : IDLE;
            READ:    stateNext = WAIT;
            WAIT:    stateNext = CMP;
            CMP:     stateNext = (loseLife && lives == LIVES_W'(1)) ? OVER : IDLE;
            default: stateNext = state;
        endcase
        if (pcs.PCS_restart) stateNext = IDLE;
    end

    assign pcs.PCS_row_rd_en = state == READ;
    assign pcs.PCS_row_addr  = state == READ ? ROWADDR_W'(PLAYER_ROW) : '0;
    assign pcs.PCS_busy      = busy;
    // Restart aborts a check even in its final cycle, so done is gated here.
    assign pcs.PCS_done      = state == CMP && !pcs.PCS_restart;
    assign pcs.PCS_hit       = pcs.PCS_done && loseLife;
    assign pcs.PCS_lives     = lives;
    assign pcs.PCS_game_over = state == OVER;
    assign pcs.PCS_overrun   = overrun;

    always_ff @(posedge PCS_CLOCK_50) begin
        if (PCS_RESET_InHigh) begin
            state    <= IDLE;
            rowLatch <= '0;
            lives    <= LIVES_W'(LIVES_INIT);
            overrun  <= 1'b0;
`ifdef PCS_GRACE_EN
            graceCnt <= '0;
`endif
        end else begin
            state <= stateNext;
            if (state == WAIT) rowLatch <= pcs.PCS_row_data;
            if (pcs.PCS_restart) begin
                lives   <= LIVES_W'(LIVES_INIT);
                overrun <= 1'b0;
`ifdef PCS_GRACE_EN
                graceCnt <= '0;
`endif
            end else begin
                if (pcs.PCS_hit) lives <= lives - LIVES_W'(1);
                if (busy && pcs.PCS_frame_tick) overrun <= 1'b1;
`ifdef PCS_GRACE_EN
                if (pcs.PCS_hit) graceCnt <= GRACE_W'(GRACE_FRAMES);
                else if (pcs.PCS_done && graceCnt != '0) graceCnt <= graceCnt - GRACE_W'(1);
`endif
            end
        end
    end
endmodule

// File: tb/tb_player_collision_sequencer.sv
// tb_player_collision_sequencer: latency-based reference model checked every cycle, plus directed literal checks.
module tb_player_collision_sequencer;
    localparam int DW = 8, AW = 3, LW = 2, LIVES_INIT = 3;
`ifdef PCS_GRACE_EN
    localparam int GRACE = 2;
    localparam int expLives[4] = '{2, 2, 2, 1};
    localparam int expHit[4]   = '{1, 0, 0, 1};
    localparam int expBusy[4]  = '{1, 1, 1, 1};
    localparam int expOver     = 0;
`else
    localparam int GRACE = 0;
    localparam int expLives[4] = '{2, 1, 0, 0};
    localparam int expHit[4]   = '{1, 1, 1, 0};
    localparam int expBusy[4]  = '{1, 1, 1, 0};
    localparam int expOver     = 1;
`endif

    logic clk = 1'b0, rst = 1'b1;
    int   total = 0, bad = 0, cyc = 0, doneCount = 0;
    int   mLives = LIVES_INIT, mGrace = 0, acc = -100;
    bit   mOver = 0, mOverrun = 0, modelOn = 0;
    logic [DW-1:0] mRow = '0;

    player_collision_sequencer_if #(.DATAWIDTH(DW), .ROWADDR_W(AW), .LIVES_W(LW)) bus ();

    player_collision_sequencer #(
        .DATAWIDTH(DW), .ROWADDR_W(AW), .PLAYER_ROW(0), .LIVES_INIT(LIVES_INIT), .LIVES_W(LW)
`ifdef PCS_GRACE_EN
        , .GRACE_FRAMES(GRACE)
`endif
    ) dut (
        .PCS_CLOCK_50(clk),
        .PCS_RESET_InHigh(rst),
        .pcs(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Model: an accepted tick at cycle N owns cycles N+1..N+3; the frame is judged at N+3.
    always @(posedge clk) begin
        int ph;
        ph = cyc - acc;
        if (rst || bus.PCS_restart) begin
            mLives = LIVES_INIT; mOver = 0; mOverrun = 0; mGrace = 0; acc = -100;
            if (rst) modelOn = 1;
        end else begin
            if (ph == 2) mRow = bus.PCS_row_data;
            if (ph == 3) begin
                if ((mRow & bus.PCS_pos_jug1) != 0 && mGrace == 0 && mLives > 0) begin
                    mLives--;
                    mGrace = GRACE;
                    if (mLives == 0) mOver = 1;
                end else if (mGrace > 0) mGrace--;
            end
            if (bus.PCS_frame_tick) begin
                if (ph >= 1 && ph <= 3) mOverrun = 1;
                else if (!mOver) acc = cyc;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        int ph;
        bit d, h;
        if (modelOn) begin
            ph = cyc - acc;
            d  = ph == 3 && !bus.PCS_restart;
            h  = d && (mRow & bus.PCS_pos_jug1) != 0 && mGrace == 0 && mLives > 0;
            check("rd_en", 32'(bus.PCS_row_rd_en), 32'(ph == 1));
            check("row_addr", 32'(bus.PCS_row_addr), 0);
            check("busy", 32'(bus.PCS_busy), 32'(ph >= 1 && ph <= 3));
            check("done", 32'(bus.PCS_done), 32'(d));
            check("hit", 32'(bus.PCS_hit), 32'(h));
            check("lives", 32'(bus.PCS_lives), 32'(mLives));
            check("game_over", 32'(bus.PCS_game_over), 32'(mOver));
            check("overrun", 32'(bus.PCS_overrun), 32'(mOverrun));
            if (bus.PCS_done === 1'b1) doneCount++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tickPulse();
        bus.PCS_frame_tick = 1'b1;
        step(1);
        bus.PCS_frame_tick = 1'b0;
    endtask

    task automatic restartPulse();
        bus.PCS_restart = 1'b1;
        step(1);
        bus.PCS_restart = 1'b0;
    endtask

    initial begin
        int d0;
        bus.PCS_frame_tick = 1'b0;
        bus.PCS_restart    = 1'b0;
        bus.PCS_pos_jug1   = 8'h08;
        bus.PCS_row_data   = 8'h00;
        step(2);
        rst = 1'b0;
        check("reset_lives", 32'(bus.PCS_lives), 3);
        check("reset_busy", 32'(bus.PCS_busy), 0);
        step(1);

        tickPulse();
        check("s1_rd_en", 32'(bus.PCS_row_rd_en), 1);
        check("s1_addr", 32'(bus.PCS_row_addr), 0);
        step(2);
        check("s1_done", 32'(bus.PCS_done), 1);
        check("s1_hit", 32'(bus.PCS_hit), 0);
        check("s1_lives", 32'(bus.PCS_lives), 3);
        step(2);

        bus.PCS_row_data = 8'h18;
        for (int i = 0; i < 4; i++) begin
            tickPulse();
            check("s2_busy", 32'(bus.PCS_busy), 32'(expBusy[i]));
            step(2);
            check("s2_hit", 32'(bus.PCS_hit), 32'(expHit[i]));
            step(1);
            check("s2_lives", 32'(bus.PCS_lives), 32'(expLives[i]));
        end
        check("s2_game_over", 32'(bus.PCS_game_over), 32'(expOver));
        restartPulse();
        check("s2_restart_lives", 32'(bus.PCS_lives), 3);
        check("s2_restart_over", 32'(bus.PCS_game_over), 0);

        bus.PCS_row_data = 8'h00;
        d0 = doneCount;
        tickPulse();
        step(1);
        tickPulse();
        step(4);
        check("s3_overrun", 32'(bus.PCS_overrun), 1);
        check("s3_one_done", 32'(doneCount - d0), 1);
        restartPulse();
        check("s3_overrun_clr", 32'(bus.PCS_overrun), 0);
        check("s3_lives", 32'(bus.PCS_lives), 3);

        bus.PCS_row_data = 8'h18;
        d0 = doneCount;
        tickPulse();
        step(1);
        restartPulse();
        check("s4_busy", 32'(bus.PCS_busy), 0);
        check("s4_lives", 32'(bus.PCS_lives), 3);
        step(1);
        check("s4_no_done", 32'(doneCount - d0), 0);
        tickPulse();
        step(2);
        restartPulse();
        check("s4_cmp_abort_lives", 32'(bus.PCS_lives), 3);
        check("s4_cmp_abort_done", 32'(doneCount - d0), 0);
        bus.PCS_frame_tick = 1'b1;
        bus.PCS_restart    = 1'b1;
        step(1);
        bus.PCS_frame_tick = 1'b0;
        bus.PCS_restart    = 1'b0;
        check("s4_tick_restart_rd", 32'(bus.PCS_row_rd_en), 0);
        check("s4_tick_restart_busy", 32'(bus.PCS_busy), 0);
        step(2);

        bus.PCS_row_data = 8'hFF;
        bus.PCS_pos_jug1 = 8'h00;
        tickPulse();
        step(3);
        check("s5_pos0_lives", 32'(bus.PCS_lives), 3);
        bus.PCS_pos_jug1 = 8'h18;
        tickPulse();
        step(3);
        check("s5_multi_lives", 32'(bus.PCS_lives), 2);
        restartPulse();

        bus.PCS_row_data = 8'h08;
        bus.PCS_pos_jug1 = 8'h00;
        tickPulse();
        step(1);
        bus.PCS_pos_jug1 = 8'h08;
        step(1);
        check("s6_late_pos_hit", 32'(bus.PCS_hit), 1);
        step(1);
        check("s6_late_pos_lives", 32'(bus.PCS_lives), 2);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end
endmodule
